// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and add/subtract op codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE_W-bit adder / true-borrow subtractor used once per clock
// by the sequential add/sub unit.
module addsub_slice
  import alu_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  input  logic               op,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c_msb
);

  // c[i] is the carry (add) or borrow (sub) entering bit i of the slice.
  always_comb begin
    logic [SLICE_W:0] c;
    c    = '0;
    c[0] = ci;
    s    = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      if (op == OP_SUB) begin
        c[i+1] = (~a[i] & b[i]) | (c[i] & ~(a[i] ^ b[i]));
      end else begin
        c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
    end
    co    = c[SLICE_W];
    c_msb = c[SLICE_W-1];
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract unit: processes SLICE_W bits per clock with a
// start/busy/done handshake and registered result and CF/OF/ZF flags.
module seq_addsub
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              CF,
  output logic              OF,
  output logic              ZF,
  output state_t            o_dbg_state
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  // Handshake: start is sampled only in IDLE or DONE (busy=0); done is a
  // one-cycle pulse and res/CF/OF/ZF stay valid until the next done.
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_op;
  logic                r_c;
  logic [DATA_W-1:0]   r_part;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_res;
  logic                r_cf;
  logic                r_of;
  logic                r_zf;

  logic [31:0]         w_base;
  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_b_sl;
  logic [SLICE_W-1:0]  w_s;
  logic                w_co;
  logic                w_c_msb;
  logic [DATA_W-1:0]   w_part_next;

  assign w_base = 32'(r_cnt) * 32'(SLICE_W);
  assign w_a_sl = r_a[w_base +: SLICE_W];
  assign w_b_sl = r_b[w_base +: SLICE_W];

  addsub_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a     (w_a_sl),
    .b     (w_b_sl),
    .ci    (r_c),
    .op    (r_op),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  // Partial result with the current slice merged in; on the last slice this
  // is the full result, so ZF can be taken from it directly.
  always_comb begin
    w_part_next                   = r_part;
    w_part_next[w_base +: SLICE_W] = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_c     <= 1'b0;
      r_part  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_cf    <= 1'b0;
      r_of    <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_c     <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_part <= w_part_next;
          r_c    <= w_co;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_res   <= w_part_next;
            r_cf    <= w_co;
            r_of    <= w_c_msb ^ w_co;
            r_zf    <= (w_part_next == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign res         = r_res;
  assign CF          = r_cf;
  assign OF          = r_of;
  assign ZF          = r_zf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: default 8-bit slicing plus 32- and 4-bit
// slice builds checked against a wide-arithmetic reference model.
module tb_seq_addsub;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic        start, op, cin;
  logic [31:0] a, b;
  logic        busy, done, cf, of, zf;
  logic [31:0] res;
  state_t      st;

  logic        v_start, v_op, v_cin;
  logic [31:0] v_a, v_b;
  logic        busy32, done32, cf32, of32, zf32;
  logic [31:0] res32;
  state_t      st32;
  logic        busy4, done4, cf4, of4, zf4;
  logic [31:0] res4;
  state_t      st4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_addsub #(.DATA_W(32), .SLICE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .res(res), .CF(cf), .OF(of), .ZF(zf),
    .o_dbg_state(st)
  );

  seq_addsub #(.DATA_W(32), .SLICE_W(32)) dut32 (
    .clk(clk), .rst(rst), .start(v_start), .op(v_op), .a(v_a), .b(v_b), .cin(v_cin),
    .busy(busy32), .done(done32), .res(res32), .CF(cf32), .OF(of32), .ZF(zf32),
    .o_dbg_state(st32)
  );

  seq_addsub #(.DATA_W(32), .SLICE_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(v_start), .op(v_op), .a(v_a), .b(v_b), .cin(v_cin),
    .busy(busy4), .done(done4), .res(res4), .CF(cf4), .OF(of4), .ZF(zf4),
    .o_dbg_state(st4)
  );

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [34:0] exp;
  } vec_t;

  function automatic logic [34:0] ref_model(input logic m_op, input logic [31:0] m_a,
                                            input logic [31:0] m_b, input logic m_cin);
    logic [32:0] w;
    longint      sd;
    logic        ovf;
    if (m_op == OP_SUB) begin
      w  = {1'b0, m_a} - {1'b0, m_b} - {32'd0, m_cin};
      sd = longint'($signed(m_a)) - longint'($signed(m_b)) - longint'(m_cin);
    end else begin
      w  = {1'b0, m_a} + {1'b0, m_b} + {32'd0, m_cin};
      sd = longint'($signed(m_a)) + longint'($signed(m_b)) + longint'(m_cin);
    end
    ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {w[31:0], w[32], ovf, (w[31:0] == 32'd0)};
  endfunction

  // Drives one operation on the default instance; returns cycles to done.
  task automatic do_op(input logic t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic t_cin, output int lat, output int busy_lo);
    start = 1'b1; op = t_op; a = t_a; b = t_b; cin = t_cin;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_lo = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) busy_lo++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    v_start = 1'b0; v_op = 1'b0; v_cin = 1'b0; v_a = '0; v_b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, res, cf, of, zf} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h cf=%b of=%b zf=%b, want all 0",
               busy, done, res, cf, of, zf);
    end
    tests++;
    if (st !== IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d want %0d", st, IDLE);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    vec_t vecs[11];
    int   lat, busy_lo;
    vecs[0]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0002, 1'b0, {32'h0000_0003, 3'b000}};
    vecs[1]  = '{OP_SUB, 32'h0000_0001, 32'h0000_0002, 1'b0, {32'hFFFF_FFFF, 3'b100}};
    vecs[2]  = '{OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 3'b110}};
    vecs[3]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 3'b010}};
    vecs[4]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 3'b101}};
    vecs[5]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 3'b010}};
    vecs[6]  = '{OP_SUB, 32'h0000_0002, 32'h0000_0001, 1'b1, {32'h0000_0000, 3'b001}};
    vecs[7]  = '{OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b1, {32'h0000_0003, 3'b000}};
    vecs[8]  = '{OP_ADD, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, {32'h0100_0000, 3'b000}};
    vecs[9]  = '{OP_SUB, 32'h0000_0100, 32'h0000_0001, 1'b0, {32'h0000_00FF, 3'b000}};
    vecs[10] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 3'b111}};
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, busy_lo);
      tests++;
      if ({res, cf, of, zf} !== vecs[i].exp) begin
        fails++;
        $display("FAIL arith[%0d]: got res=%h cf/of/zf=%b%b%b, want res=%h cf/of/zf=%b",
                 i, res, cf, of, zf, vecs[i].exp[34:3], vecs[i].exp[2:0]);
      end
      tests++;
      if (lat != 4 || busy_lo != 0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL arith_timing[%0d]: got latency=%0d busy_low=%0d busy_at_done=%b, want 4/0/0",
                 i, lat, busy_lo, busy);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || res !== vecs[i].exp[34:3]) begin
        fails++;
        $display("FAIL arith_after_done[%0d]: got done=%b res=%h, want done=0 res=%h",
                 i, done, res, vecs[i].exp[34:3]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1'b1; op = OP_SUB; a = 32'd5; b = 32'd2; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = OP_ADD; a = 32'h100; b = 32'h200; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if ({res, cf, of, zf} !== {32'd3, 3'b000} || lat != 4) begin
      fails++;
      $display("FAIL ignore_start: got res=%h flags=%b%b%b lat=%0d, want res=3 flags=000 lat=4",
               res, cf, of, zf, lat);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || st !== IDLE) begin
      fails++;
      $display("FAIL ignore_start_idle: got busy=%b state=%0d, want 0/%0d", busy, st, IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_lo, k;
    do_op(OP_SUB, 32'h10, 32'h1, 1'b0, lat, busy_lo);
    start = 1'b1; op = OP_ADD; a = 32'h20; b = 32'h22; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || res !== 32'h0000_000F) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b done=%b res=%h, want 1/0/0000000f", busy, done, res);
    end
    k = 1;
    while (done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if ({res, cf, of, zf} !== {32'h42, 3'b000} || k != 5) begin
      fails++;
      $display("FAIL b2b_second: got res=%h flags=%b%b%b gap=%0d, want res=42 flags=000 gap=5",
               res, cf, of, zf, k);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, busy_lo, seen;
    start = 1'b1; op = OP_ADD; a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, res, cf, of, zf} !== 37'd0 || st !== IDLE) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b res=%h flags=%b%b%b state=%0d, want all 0 IDLE",
               busy, done, res, cf, of, zf, st);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    tests++;
    if (seen != 0 || res !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got done_pulses=%0d res=%h, want 0/0", seen, res);
    end
    do_op(OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, lat, busy_lo);
    tests++;
    if ({res, cf, of, zf} !== {32'h3333_3333, 3'b000} || lat != 4) begin
      fails++;
      $display("FAIL reset_mid_restart: got res=%h flags=%b%b%b lat=%0d, want 33333333/000/4",
               res, cf, of, zf, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_widths();
    logic [34:0] exp;
    int          lat32, lat4;
    for (int i = 0; i < 1000; i++) begin
      v_op  = 1'($urandom_range(0, 1));
      v_cin = 1'($urandom_range(0, 1));
      v_a   = $urandom;
      v_b   = $urandom;
      if (i < 4) begin
        v_a = (i[0]) ? 32'h7FFF_FFFF : 32'h8000_0000;
        v_b = (i[1]) ? 32'hFFFF_FFFF : 32'h0000_0001;
      end
      exp = ref_model(v_op, v_a, v_b, v_cin);
      v_start = 1'b1;
      @(posedge clk); #1;
      v_start = 1'b0;
      lat32 = -1;
      lat4  = -1;
      for (int k = 0; k < 12; k++) begin
        if (done32 === 1'b1 && lat32 < 0) lat32 = k;
        if (done4 === 1'b1 && lat4 < 0) lat4 = k;
        @(posedge clk); #1;
      end
      tests++;
      if ({res32, cf32, of32, zf32} !== exp || lat32 != 1) begin
        fails++;
        $display("FAIL slice32[%0d] op=%b a=%h b=%h cin=%b: got %h_%b%b%b lat=%0d, want %h_%b lat=1",
                 i, v_op, v_a, v_b, v_cin, res32, cf32, of32, zf32, lat32, exp[34:3], exp[2:0]);
      end
      tests++;
      if ({res4, cf4, of4, zf4} !== exp || lat4 != 8) begin
        fails++;
        $display("FAIL slice4[%0d] op=%b a=%h b=%h cin=%b: got %h_%b%b%b lat=%0d, want %h_%b lat=8",
                 i, v_op, v_a, v_b, v_cin, res4, cf4, of4, zf4, lat4, exp[34:3], exp[2:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_widths();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
